sliced_serial_alu: RTL and testbench

- Parametrised successor to the 4-bit bit-slice ALU with carry lookahead.
- Processes WIDTH-bit operands as a chain of SLICE-bit slices, one slice per clock, LSB slice first.
- The inter-slice carry is held in a register, so one slice-width datapath serves any word width.
- Sits between the operand registers and the result bus; uses a START/BUSY/DONE handshake.

---
 rtl/sliced_serial_alu.sv | 131 +++++++++++++
 tb/tb_sliced_serial_alu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliced_serial_alu.sv
// Bit-serial-by-slice ALU: WIDTH-bit operands processed SLICE bits per clock, LSB slice first.
// Optional overflow output V enabled by defining SLICED_ALU_OVF_EN.
module sliced_serial_alu #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       S,
   input  logic             M,
   input  logic             Pin,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] R,
   output logic             Pout,
`ifdef SLICED_ALU_OVF_EN
   output logic             V,
`endif
   output logic             ZERO
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   logic             state;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] partial;
   logic [WIDTH-1:0] opa, opb;
   logic [1:0]       ops;
   logic             opm;

   logic [SLICE-1:0] sa, sb, bsel, rs;
   logic [SLICE:0]   sum;
   logic             cn;
   logic [WIDTH-1:0] partial_n;
`ifdef SLICED_ALU_OVF_EN
   logic             vn;
`endif

   assign BUSY = (state == RUN);

   always_comb begin
      sa = opa[cnt*SLICE +: SLICE];
      sb = opb[cnt*SLICE +: SLICE];
      case (ops)
         2'b00:   bsel = sb;
         2'b01:   bsel = ~sb;
         2'b10:   bsel = '0;
         default: bsel = '1;
      endcase
      sum = {1'b0, sa} + {1'b0, bsel} + {{SLICE{1'b0}}, carry};
      if (opm) begin
         case (ops)
            2'b00:   rs = sa & sb;
            2'b01:   rs = sa | sb;
            2'b10:   rs = sa ^ sb;
            default: rs = ~sa;
         endcase
         cn = 1'b0;
      end else begin
         rs = sum[SLICE-1:0];
         cn = sum[SLICE];
      end
      partial_n = partial;
      partial_n[cnt*SLICE +: SLICE] = rs;
`ifdef SLICED_ALU_OVF_EN
      // carry into the MSB recovered from its sum bit and its two addend bits
      vn = ~opm & (sum[SLICE] ^ sum[SLICE-1] ^ sa[SLICE-1] ^ bsel[SLICE-1]);
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         carry   <= 1'b0;
         partial <= '0;
         opa     <= '0;
         opb     <= '0;
         ops     <= '0;
         opm     <= 1'b0;
         DONE    <= 1'b0;
         R       <= '0;
         Pout    <= 1'b0;
         ZERO    <= 1'b0;
`ifdef SLICED_ALU_OVF_EN
         V       <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (START) begin
                  opa     <= A;
                  opb     <= B;
                  ops     <= S;
                  opm     <= M;
                  carry   <= M ? 1'b0 : Pin;
                  cnt     <= '0;
                  partial <= '0;
                  state   <= RUN;
               end
            end
            default: begin
               partial <= partial_n;
               carry   <= cn;
               cnt     <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= IDLE;
                  R     <= partial_n;
                  Pout  <= cn;
                  ZERO  <= (partial_n == '0);
                  DONE  <= 1'b1;
`ifdef SLICED_ALU_OVF_EN
                  V     <= vn;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sliced_serial_alu.sv
// Self-checking bench for sliced_serial_alu (WIDTH=16, SLICE=4) against a whole-word arithmetic model.
module tb_sliced_serial_alu;

   logic        CLK, RST, START;
   logic [15:0] A, B;
   logic [1:0]  S;
   logic        M, Pin;
   logic        BUSY, DONE, Pout, ZERO;
   logic [15:0] R;
`ifdef SLICED_ALU_OVF_EN
   logic        V;
`endif

   int tests = 0;
   int fails = 0;

   sliced_serial_alu #(.WIDTH(16), .SLICE(4)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .S(S), .M(M), .Pin(Pin),
      .BUSY(BUSY), .DONE(DONE), .R(R), .Pout(Pout),
`ifdef SLICED_ALU_OVF_EN
      .V(V),
`endif
      .ZERO(ZERO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // returns {v, pout, r} for the full word
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] s, input logic m, input logic pin);
      logic [16:0] full;
      logic [15:0] bo, r;
      logic        c, v;
      if (m) begin
         case (s)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = ~a;
         endcase
         c = 1'b0;
         v = 1'b0;
      end else begin
         case (s)
            2'd0:    bo = b;
            2'd1:    bo = ~b;
            2'd2:    bo = 16'h0000;
            default: bo = 16'hFFFF;
         endcase
         full = {1'b0, a} + {1'b0, bo} + 17'(pin);
         r = full[15:0];
         c = full[16];
         v = (a[15] == bo[15]) && (r[15] != a[15]);
      end
      return {v, c, r};
   endfunction

   task automatic scramble();
      A = 16'($urandom); B = 16'($urandom); S = 2'($urandom);
      M = 1'($urandom); Pin = 1'($urandom);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] s,
                         input logic m, input logic pin, output int lat, output int bcnt);
      @(negedge CLK);
      A = a; B = b; S = s; M = m; Pin = pin; START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      scramble();
      lat = 0; bcnt = 0;
      while (!DONE && lat < 20) begin
         if (BUSY) bcnt++;
         @(negedge CLK);
         lat++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; START = 1'b0; A = '0; B = '0; S = '0; M = 1'b0; Pin = 1'b0;
      #1;
      tests++;
      if ({R, Pout, ZERO, DONE, BUSY} !== 20'h0) begin
         fails++;
         $display("FAIL reset_state: got R=%h Pout=%b ZERO=%b DONE=%b BUSY=%b, want all 0",
                  R, Pout, ZERO, DONE, BUSY);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_directed();
      logic [15:0] va [5]  = '{16'hFFFF, 16'h1234, 16'h0001, 16'hF0F0, 16'h00FF};
      logic [15:0] vb [5]  = '{16'h0001, 16'h0034, 16'h0002, 16'hFF00, 16'h0000};
      logic [1:0]  vs [5]  = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
      logic        vm [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        vp [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [15:0] er [5]  = '{16'h0000, 16'h1200, 16'hFFFF, 16'h0FF0, 16'hFF00};
      logic        ep [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int lat, bcnt;
      for (int i = 0; i < 5; i++) begin
         run_op(va[i], vb[i], vs[i], vm[i], vp[i], lat, bcnt);
         tests++;
         if (lat != 4 || bcnt != 4 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d BUSY=%b, want 4 4 0", i, lat, bcnt, BUSY);
         end
         tests++;
         if (R !== er[i] || Pout !== ep[i] || ZERO !== (er[i] == 16'h0)) begin
            fails++;
            $display("FAIL directed_result[%0d]: got R=%h Pout=%b ZERO=%b, want R=%h Pout=%b ZERO=%b",
                     i, R, Pout, ZERO, er[i], ep[i], er[i] == 16'h0);
         end
      end
      @(negedge CLK);
      tests++;
      if (DONE !== 1'b0 || R !== 16'hFF00) begin
         fails++;
         $display("FAIL done_pulse_hold: got DONE=%b R=%h, want DONE=0 R=ff00", DONE, R);
      end
   endtask

   task automatic test_random();
      logic [15:0] a, b;
      logic [1:0]  s;
      logic        m, p;
      logic [17:0] e;
      int lat, bcnt;
      for (int i = 0; i < 150; i++) begin
         a = 16'($urandom); b = 16'($urandom); s = 2'($urandom);
         m = 1'($urandom); p = 1'($urandom);
         if (i % 10 == 0) b = a;
         e = model(a, b, s, m, p);
         run_op(a, b, s, m, p, lat, bcnt);
         tests++;
         if (lat != 4 || R !== e[15:0] || Pout !== e[16] || ZERO !== (e[15:0] == 16'h0)) begin
            fails++;
            $display("FAIL random[%0d]: a=%h b=%h s=%0d m=%b p=%b got lat=%0d R=%h Pout=%b ZERO=%b, want 4 %h %b %b",
                     i, a, b, s, m, p, lat, R, Pout, ZERO, e[15:0], e[16], e[15:0] == 16'h0);
         end
`ifdef SLICED_ALU_OVF_EN
         tests++;
         if (V !== e[17]) begin
            fails++;
            $display("FAIL random_v[%0d]: got V=%b, want %b", i, V, e[17]);
         end
`endif
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge CLK);
      A = 16'h1111; B = 16'h2222; S = 2'b00; M = 1'b0; Pin = 1'b0; START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      A = 16'h0F0F; B = 16'h0101;
      lat = 0;
      while (!DONE && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      tests++;
      if (lat != 4 || R !== 16'h3333 || Pout !== 1'b0) begin
         fails++;
         $display("FAIL busy_ignore: got lat=%0d R=%h Pout=%b, want 4 3333 0", lat, R, Pout);
      end
      @(negedge CLK);
      START = 1'b0;
      scramble();
      tests++;
      if (BUSY !== 1'b1) begin
         fails++;
         $display("FAIL b2b_accept: got BUSY=%b, want 1", BUSY);
      end
      lat = 0;
      while (!DONE && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      tests++;
      if (lat != 4 || R !== 16'h1010 || Pout !== 1'b0) begin
         fails++;
         $display("FAIL b2b_result: got lat=%0d R=%h Pout=%b, want 4 1010 0", lat, R, Pout);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, seen;
      run_op(16'h00FF, 16'h0000, 2'b01, 1'b1, 1'b0, lat, bcnt);
      tests++;
      if (R !== 16'h00FF) begin
         fails++;
         $display("FAIL pre_reset_op: got R=%h, want 00ff", R);
      end
      @(negedge CLK);
      A = 16'hFFFF; B = 16'h0001; S = 2'b00; M = 1'b0; Pin = 1'b0; START = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      #1;
      tests++;
      if ({R, Pout, ZERO, DONE, BUSY} !== 20'h0) begin
         fails++;
         $display("FAIL reset_mid: got R=%h Pout=%b ZERO=%b DONE=%b BUSY=%b, want all 0",
                  R, Pout, ZERO, DONE, BUSY);
      end
      @(negedge CLK);
      RST = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         if (DONE || BUSY) seen++;
      end
      tests++;
      if (seen != 0) begin
         fails++;
         $display("FAIL reset_no_done: got %0d active cycles, want 0", seen);
      end
      run_op(16'hABCD, 16'h1111, 2'b00, 1'b0, 1'b1, lat, bcnt);
      tests++;
      if (lat != 4 || R !== 16'hBCDF || Pout !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_op: got lat=%0d R=%h Pout=%b, want 4 bcdf 0", lat, R, Pout);
      end
   endtask

`ifdef SLICED_ALU_OVF_EN
   task automatic test_ovf();
      int lat, bcnt;
      run_op(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, lat, bcnt);
      tests++;
      if (R !== 16'h8000 || V !== 1'b1 || Pout !== 1'b0) begin
         fails++;
         $display("FAIL ovf_pos: got R=%h V=%b Pout=%b, want 8000 1 0", R, V, Pout);
      end
      run_op(16'h8000, 16'h8000, 2'b00, 1'b0, 1'b0, lat, bcnt);
      tests++;
      if (R !== 16'h0000 || V !== 1'b1 || Pout !== 1'b1) begin
         fails++;
         $display("FAIL ovf_neg: got R=%h V=%b Pout=%b, want 0000 1 1", R, V, Pout);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef SLICED_ALU_OVF_EN
      test_ovf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
